// File: rtl/keypad_frontend.sv
// keypad_frontend: 4x4 active-low matrix keypad scanner with row synchroniser,
// frame-based debounce FSM and key decode into one-cycle digit/command strobes.
// Optional idle auto-clear is compiled in when KEYPAD_TIMEOUT_EN is defined.
module keypad_frontend #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] digit,
    output logic       input_digit,
    output logic [1:0] command
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESS   = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser and scan timing
    // ------------------------------------------------------------------
    logic [3:0]       r_row_s1;
    logic [3:0]       r_row_s2;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_col;
    logic             w_sample;
    logic             w_frame_end;

    // Two-flop synchroniser for the asynchronous row inputs (idle high).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row_s1 <= 4'hF;
            r_row_s2 <= 4'hF;
        end else begin
            r_row_s1 <= row_n;
            r_row_s2 <= r_row_s1;
        end
    end

    assign w_sample    = (r_div == DIV_W'(SCAN_DIV - 1));
    assign w_frame_end = w_sample && (r_col == 2'd3);

    // Column dwell counter and column index; column 0 is driven out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
            r_col <= 2'd0;
        end else if (w_sample) begin
            r_div <= '0;
            r_col <= r_col + 2'd1;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    assign col_n = ~(4'b0001 << r_col);

    // ------------------------------------------------------------------
    // Frame accumulation: count lows across the four column samples
    // ------------------------------------------------------------------
    logic [3:0] w_low;
    logic [2:0] w_cur_cnt;
    logic [1:0] w_cur_row;
    logic [2:0] w_sum;
    logic [1:0] w_lows_sat;
    logic [3:0] w_key_now;
    logic       w_res_none;
    logic       w_res_key;
    logic [1:0] r_lows;
    logic [3:0] r_key;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row_low
            assign w_low[gi] = ~r_row_s2[gi];
        end
    endgenerate

    // Number of low rows in the current column sample and which row it was.
    always_comb begin
        w_cur_cnt = 3'd0;
        w_cur_row = 2'd0;
        for (int i = 0; i < 4; i++) begin
            w_cur_cnt = w_cur_cnt + {2'b00, w_low[i]};
        end
        for (int i = 3; i >= 0; i--) begin
            if (w_low[i]) begin
                w_cur_row = 2'(i);
            end
        end
    end

    // Running total saturates at 2 ("more than one"), which is all that matters.
    always_comb begin
        w_sum      = {1'b0, r_lows} + w_cur_cnt;
        w_lows_sat = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
        w_key_now  = (w_cur_cnt == 3'd1) ? {w_cur_row, r_col} : r_key;
        w_res_none = (w_sum == 3'd0);
        w_res_key  = (w_sum == 3'd1);
    end

    // Accumulator is cleared at each frame end so the next frame starts fresh.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lows <= 2'd0;
            r_key  <= 4'd0;
        end else if (w_sample) begin
            if (w_frame_end) begin
                r_lows <= 2'd0;
            end else begin
                r_lows <= w_lows_sat;
            end
            if (w_cur_cnt == 3'd1) begin
                r_key <= {w_cur_row, r_col};
            end
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM (advances only at frame end)
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [3:0]       r_cand;
    logic [3:0]       w_cand_next;
    logic             w_accept;

    // State register with candidate key and frame counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cand  <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_cand  <= w_cand_next;
        end
    end

    // Next-state logic; MULTI counts as "no key" for press and "held" for release.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_cand_next  = r_cand;
        w_accept     = 1'b0;
        if (w_frame_end) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_res_key) begin
                        w_cand_next = w_key_now;
                        if (DEBOUNCE == 1) begin
                            w_accept     = 1'b1;
                            w_state_next = ST_HELD;
                        end else begin
                            w_state_next = ST_PRESS;
                            w_cnt_next   = CNT_W'(1);
                        end
                    end
                end
                ST_PRESS: begin
                    if (w_res_key && (w_key_now == r_cand)) begin
                        if (r_cnt == CNT_W'(DEBOUNCE - 1)) begin
                            w_accept     = 1'b1;
                            w_state_next = ST_HELD;
                        end else begin
                            w_cnt_next = r_cnt + CNT_W'(1);
                        end
                    end else if (w_res_key) begin
                        w_cand_next = w_key_now;
                        w_cnt_next  = CNT_W'(1);
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (w_res_none) begin
                        if (DEBOUNCE == 1) begin
                            w_state_next = ST_IDLE;
                        end else begin
                            w_state_next = ST_RELEASE;
                            w_cnt_next   = CNT_W'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    if (w_res_none) begin
                        if (r_cnt == CNT_W'(DEBOUNCE - 1)) begin
                            w_state_next = ST_IDLE;
                        end else begin
                            w_cnt_next = r_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_state_next = ST_HELD;
                    end
                end
            endcase
        end
    end

    // Output decode of the accepted key into digit / command events.
    logic       w_is_digit;
    logic       w_is_cmd;
    logic [3:0] w_digit_val;
    logic [1:0] w_cmd_val;
    logic       w_emit_digit;
    logic       w_emit_cmd;

    always_comb begin
        w_is_digit  = 1'b0;
        w_is_cmd    = 1'b0;
        w_digit_val = 4'd0;
        w_cmd_val   = 2'b00;
        case (w_key_now)
            4'd0:  begin w_is_digit = 1'b1; w_digit_val = 4'd1; end
            4'd1:  begin w_is_digit = 1'b1; w_digit_val = 4'd2; end
            4'd2:  begin w_is_digit = 1'b1; w_digit_val = 4'd3; end
            4'd4:  begin w_is_digit = 1'b1; w_digit_val = 4'd4; end
            4'd5:  begin w_is_digit = 1'b1; w_digit_val = 4'd5; end
            4'd6:  begin w_is_digit = 1'b1; w_digit_val = 4'd6; end
            4'd8:  begin w_is_digit = 1'b1; w_digit_val = 4'd7; end
            4'd9:  begin w_is_digit = 1'b1; w_digit_val = 4'd8; end
            4'd10: begin w_is_digit = 1'b1; w_digit_val = 4'd9; end
            4'd13: begin w_is_digit = 1'b1; w_digit_val = 4'd0; end
            4'd3:  begin w_is_cmd = 1'b1; w_cmd_val = 2'b01; end
            4'd7:  begin w_is_cmd = 1'b1; w_cmd_val = 2'b10; end
            4'd11: begin w_is_cmd = 1'b1; w_cmd_val = 2'b11; end
            default: begin end
        endcase
        w_emit_digit = w_accept && enable && w_is_digit;
        w_emit_cmd   = w_accept && enable && w_is_cmd;
    end

    // ------------------------------------------------------------------
    // Idle auto-clear
    // ------------------------------------------------------------------
    logic w_to_fire;

`ifdef KEYPAD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic            r_to_active;
    logic [TO_W-1:0] r_to_cnt;

    assign w_to_fire = w_frame_end && !w_accept && r_to_active &&
                       (r_state == ST_IDLE) && (r_to_cnt == TO_W'(TIMEOUT - 1));

    // Armed by an emitted digit, counts idle frames, disarms on fire or command.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to_active <= 1'b0;
            r_to_cnt    <= '0;
        end else if (w_frame_end) begin
            if (w_accept) begin
                r_to_cnt <= '0;
                if (w_emit_digit) begin
                    r_to_active <= 1'b1;
                end else if (w_is_cmd) begin
                    r_to_active <= 1'b0;
                end
            end else if (r_to_active && (r_state == ST_IDLE)) begin
                if (w_to_fire) begin
                    r_to_active <= 1'b0;
                    r_to_cnt    <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                end
            end
        end
    end
`else
    assign w_to_fire = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Registered strobes: they appear the cycle after the frame-end evaluation.
    // ------------------------------------------------------------------
    logic [3:0] r_digit;
    logic       r_input_digit;
    logic [1:0] r_command;

    // Key commands and the timeout are mutually exclusive (timeout needs no accept).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_digit       <= 4'd0;
            r_input_digit <= 1'b0;
            r_command     <= 2'b00;
        end else begin
            r_input_digit <= w_emit_digit;
            if (w_emit_digit) begin
                r_digit <= w_digit_val;
            end
            if (w_emit_cmd) begin
                r_command <= w_cmd_val;
            end else if (w_to_fire && enable) begin
                r_command <= 2'b11;
            end else begin
                r_command <= 2'b00;
            end
        end
    end

    assign digit       = r_digit;
    assign input_digit = r_input_digit;
    assign command     = r_command;

endmodule
